// File: rtl/cluster_component_accumulator_pkg.sv
// Shared widths, types and FSM state encoding for the K-means centroid accumulator path.
// Default widths keep a full-count sum (4095*255) below the sum ceiling.
package kmeans_pkg;
  localparam int NUM_CLUSTERS = 16;
  localparam int PIX_W        = 8;
  localparam int SUM_W        = 20;
  localparam int CNT_W        = 12;
  localparam int ID_W         = $clog2(NUM_CLUSTERS);

  typedef logic [ID_W-1:0]  cluster_id_t;
  typedef logic [PIX_W-1:0] comp_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {IDLE, ACCUM, DIV_ARM, DIV_WAIT, DONE} acc_state_t;
endpackage

// File: rtl/cluster_component_accumulator_if.sv
// Pixel stream, divider handshake and result bus of the component accumulator.
// ACCUM_SAT_STATUS_EN adds the sticky per-cluster saturation mask.
interface cluster_component_accumulator_if;
  logic                                          ce_i;
  logic                                          start_i;
  logic                                          pix_valid_i;
  kmeans_pkg::comp_t                             pix_comp_i;
  kmeans_pkg::cluster_id_t                       pix_cluster_i;
  logic                                          pix_last_i;
  logic                                          div_all_ready_i;
  logic [kmeans_pkg::NUM_CLUSTERS-1:0]           div_en_o;
  logic [kmeans_pkg::NUM_CLUSTERS*kmeans_pkg::SUM_W-1:0] dividend_o;
  logic [kmeans_pkg::NUM_CLUSTERS*kmeans_pkg::CNT_W-1:0] divisor_o;
  logic                                          busy_o;
  logic                                          done_o;
`ifdef ACCUM_SAT_STATUS_EN
  logic [kmeans_pkg::NUM_CLUSTERS-1:0]           sat_mask_o;
`endif

  modport master (
    output ce_i, start_i, pix_valid_i, pix_comp_i, pix_cluster_i, pix_last_i, div_all_ready_i,
    input  div_en_o, dividend_o, divisor_o, busy_o, done_o
`ifdef ACCUM_SAT_STATUS_EN
    , input sat_mask_o
`endif
  );

  modport slave (
    input  ce_i, start_i, pix_valid_i, pix_comp_i, pix_cluster_i, pix_last_i, div_all_ready_i,
    output div_en_o, dividend_o, divisor_o, busy_o, done_o
`ifdef ACCUM_SAT_STATUS_EN
    , output sat_mask_o
`endif
  );
endinterface

// File: rtl/cluster_component_accumulator_cell.sv
// One cluster's saturating sum/count pair; clear wins over increment.
// A pixel is dropped entirely once the count is full so sum/count stay a consistent mean.
module cluster_acc_cell
  import kmeans_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  inc_i,
  input  comp_t comp_i,
  output sum_t  sum_o,
  output cnt_t  cnt_o,
  output logic  sat_o
);
  sum_t           sum_q, sum_d;
  cnt_t           cnt_q, cnt_d;
  logic [SUM_W:0] sum_ext;
  logic           cnt_full;
  logic           sum_ovf;

  assign cnt_full = (cnt_q == '1);
  assign sum_ext  = {1'b0, sum_q} + {{(SUM_W+1-PIX_W){1'b0}}, comp_i};
  assign sum_ovf  = sum_ext[SUM_W];
  assign sat_o    = inc_i && !clr_i && (cnt_full || sum_ovf);

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (inc_i && !cnt_full) begin
      cnt_d = cnt_q + cnt_t'(1);
      sum_d = sum_ovf ? '1 : sum_ext[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o = sum_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/cluster_component_accumulator.sv
// Per-cluster component sum/count accumulator feeding the centroid divider; FSM and div_en live here.
// ACCUM_SAT_STATUS_EN adds a sticky sat_mask output, cleared by reset and start.
module cluster_component_accumulator
  import kmeans_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  cluster_component_accumulator_if.slave  bus
);
  acc_state_t              state_q, state_d;
  logic [NUM_CLUSTERS-1:0] div_en_q, div_en_d;
  logic [NUM_CLUSTERS-1:0] inc;
  logic [NUM_CLUSTERS-1:0] sat;
  sum_t                    sums [NUM_CLUSTERS];
  cnt_t                    cnts [NUM_CLUSTERS];
  logic                    clr;
  logic                    acc_fire;

  // A pixel coinciding with start is dropped: the clear takes priority.
  assign clr      = bus.ce_i && bus.start_i && (state_q == IDLE || state_q == ACCUM);
  assign acc_fire = bus.ce_i && (state_q == ACCUM) && bus.pix_valid_i && !bus.start_i;

  for (genvar k = 0; k < NUM_CLUSTERS; k++) begin : g_cell
    assign inc[k] = acc_fire && (bus.pix_cluster_i == cluster_id_t'(k));

    cluster_acc_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .inc_i  (inc[k]),
      .comp_i (bus.pix_comp_i),
      .sum_o  (sums[k]),
      .cnt_o  (cnts[k]),
      .sat_o  (sat[k])
    );

    assign bus.dividend_o[k*SUM_W +: SUM_W] = sums[k];
    assign bus.divisor_o[k*CNT_W +: CNT_W]  = cnts[k];
  end

  always_comb begin
    state_d  = state_q;
    div_en_d = div_en_q;
    if (bus.ce_i) begin
      case (state_q)
        IDLE:     if (bus.start_i) state_d = ACCUM;
        ACCUM: begin
          if (bus.start_i)                            state_d = ACCUM;
          else if (bus.pix_valid_i && bus.pix_last_i) state_d = DIV_ARM;
        end
        // Ready is not looked at here: it may still reflect the previous frame.
        DIV_ARM: begin
          state_d = DIV_WAIT;
          for (int k = 0; k < NUM_CLUSTERS; k++) div_en_d[k] = (cnts[k] != '0);
        end
        DIV_WAIT: if (bus.div_all_ready_i) state_d = DONE;
        DONE: begin
          state_d  = IDLE;
          div_en_d = '0;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_en_q <= '0;
    end else begin
      state_q  <= state_d;
      div_en_q <= div_en_d;
    end
  end

  assign bus.div_en_o = div_en_q;
  assign bus.busy_o   = (state_q == ACCUM) || (state_q == DIV_ARM) || (state_q == DIV_WAIT);
  assign bus.done_o   = (state_q == DONE);

`ifdef ACCUM_SAT_STATUS_EN
  logic [NUM_CLUSTERS-1:0] sat_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sat_mask_q <= '0;
    else if (clr) sat_mask_q <= '0;
    else          sat_mask_q <= sat_mask_q | sat;
  end

  assign bus.sat_mask_o = sat_mask_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat;
`endif
endmodule
